// File: rtl/onehot_demux6.sv
// onehot_demux6: six-lane one-hot distributor.
// A valid/ready stream of WIDTH-bit words is steered into six one-entry
// registered lane slots. By default the lane is picked round-robin by the
// one-hot pointer `sel`. With ONEHOT_DEMUX6_ADDR_EN defined, each word
// carries an explicit lane index on in_dest. In that mode, indices 6 and 7
// are consumed, dropped, and flagged on err.
module onehot_demux6 #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef ONEHOT_DEMUX6_ADDR_EN
  input  logic [2:0]       in_dest,
`endif
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [WIDTH-1:0] out_4,
  output logic [WIDTH-1:0] out_5,
  output logic [5:0]       out_valid,
  input  logic [5:0]       out_ready,
  output logic [5:0]       sel,
  output logic             err
);

  logic [WIDTH-1:0] data_q [6];
  logic [5:0]       valid_q, valid_d;
  logic [5:0]       sel_q, sel_d;
  logic [5:0]       tgt_oh;
  logic [5:0]       fill;
  logic             illegal;
  logic             accept;

  // Target lane as a one-hot vector; an illegal index selects no lane.
  always_comb begin
    tgt_oh  = '0;
    illegal = 1'b0;
`ifdef ONEHOT_DEMUX6_ADDR_EN
    case (in_dest)
      3'd0: tgt_oh = 6'b000001;
      3'd1: tgt_oh = 6'b000010;
      3'd2: tgt_oh = 6'b000100;
      3'd3: tgt_oh = 6'b001000;
      3'd4: tgt_oh = 6'b010000;
      3'd5: tgt_oh = 6'b100000;
      default: illegal = 1'b1;
    endcase
`else
    tgt_oh = sel_q;
`endif
  end

  // Accept when the target slot is empty or draining this very cycle.
  // An illegal word is always accepted so that it can be discarded.
  always_comb begin
    in_ready = !rst && (illegal || (|(tgt_oh & (~valid_q | out_ready))));
    accept   = in_valid && in_ready;
    fill     = accept ? tgt_oh : '0;
  end

  // Next lane flags: a refill wins over a drain in the same cycle.
  always_comb begin
    valid_d = fill | (valid_q & ~out_ready);
  end

  // Pointer advance: rotate left on every accept; it stays fixed when lanes are addressed.
  always_comb begin
    sel_d = sel_q;
`ifdef ONEHOT_DEMUX6_ADDR_EN
    sel_d = 6'b000001;
`else
    if (accept) sel_d = {sel_q[4:0], sel_q[5]};
`endif
  end

  // Lane flags and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      sel_q   <= 6'b000001;
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  // Lane data slots; data is kept after a drain and is only overwritten on refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < 6; k++) data_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 6; k++)
        if (fill[k]) data_q[k] <= in_data;
    end
  end

`ifdef ONEHOT_DEMUX6_ADDR_EN
  logic err_q, err_d;

  // A dropped illegal-destination word raises err for exactly one cycle.
  always_comb begin
    err_d = accept && illegal;
  end

  // Error pulse register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign out_0     = data_q[0];
  assign out_1     = data_q[1];
  assign out_2     = data_q[2];
  assign out_3     = data_q[3];
  assign out_4     = data_q[4];
  assign out_5     = data_q[5];
  assign out_valid = valid_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_onehot_demux6.sv
// Testbench for onehot_demux6: directed steps plus randomized traffic,
// checked against a lane-array reference model.
module tb_onehot_demux6;

  localparam int unsigned WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_dest;
  logic [WIDTH-1:0] out_0, out_1, out_2, out_3, out_4, out_5;
  logic [5:0]       out_valid;
  logic [5:0]       out_ready;
  logic [5:0]       sel;
  logic             err;

  int checks   = 0;
  int failures = 0;

  // Reference model: lane contents, lane-full flags, pointer index, error flag.
  int m_data [6];
  bit m_full [6];
  int m_ptr;
  bit m_err;

  onehot_demux6 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef ONEHOT_DEMUX6_ADDR_EN
    .in_dest   (in_dest),
`endif
    .out_0     (out_0),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_3     (out_3),
    .out_4     (out_4),
    .out_5     (out_5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lane_word(input int k);
    case (k)
      0: return int'(out_0);
      1: return int'(out_1);
      2: return int'(out_2);
      3: return int'(out_3);
      4: return int'(out_4);
      default: return int'(out_5);
    endcase
  endfunction

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  // Returns the in_ready value the model predicted.
  task automatic step(input bit r, input bit v, input int d, input int ordy, input int dst,
                      output bit rdy);
    int  tgt;
    bit  ill;
    bit  acc;
    int  vexp;
    rst       = r;
    in_valid  = v;
    in_data   = WIDTH'(d);
    out_ready = 6'(ordy);
    in_dest   = 3'(dst);
    #1;
`ifdef ONEHOT_DEMUX6_ADDR_EN
    tgt = dst;
    ill = (dst > 5);
`else
    tgt = m_ptr;
    ill = 1'b0;
`endif
    rdy = !r && (ill || !m_full[tgt] || ordy[tgt]);
    chk("in_ready", int'(in_ready), int'(rdy));
    acc = v && rdy;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 6; k++) begin m_data[k] = 0; m_full[k] = 0; end
      m_ptr = 0;
      m_err = 0;
    end else begin
      for (int k = 0; k < 6; k++) if (ordy[k]) m_full[k] = 0;
      m_err = acc && ill;
      if (acc && !ill) begin
        m_data[tgt] = d;
        m_full[tgt] = 1;
`ifndef ONEHOT_DEMUX6_ADDR_EN
        m_ptr = (m_ptr + 1) % 6;
`endif
      end
    end
    #1;
    vexp = 0;
    for (int k = 0; k < 6; k++) if (m_full[k]) vexp += (1 << k);
    chk("out_valid", int'(out_valid), vexp);
    for (int k = 0; k < 6; k++) chk($sformatf("out_%0d", k), lane_word(k), m_data[k]);
    chk("sel", int'(sel), 1 << m_ptr);
    chk("err", int'(err), int'(m_err));
  endtask

  initial begin
    bit rdy;
    int nready;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = '0; in_dest = '0;
    for (int k = 0; k < 6; k++) begin m_data[k] = 0; m_full[k] = 0; end
    m_ptr = 0; m_err = 0;
    @(posedge clk); #1;

    // Reset state.
    step(1, 0, 0, 0, 0, rdy);
    step(1, 1, 5, 0, 0, rdy);
    chk("ready_in_reset", int'(in_ready), 0);

`ifndef ONEHOT_DEMUX6_ADDR_EN
    // Round-robin burst of words 1..7 into stalled lanes.
    for (int w = 1; w <= 6; w++) begin
      step(0, 1, w, 0, 0, rdy);
      chk("burst_ready", int'(rdy), 1);
    end
    step(0, 1, 7, 0, 0, rdy);
    chk("word7_blocked", int'(in_ready), 0);
    chk("word7_sel", int'(sel), 1);

    // Same-cycle drain and refill of lane 0.
    step(0, 1, 7, 6'b000001, 0, rdy);
    chk("refill_out0", int'(out_0), 7);
    chk("refill_valid0", int'(out_valid[0]), 1);
    chk("refill_sel", int'(sel), 2);

    // Advance to lane 2 and hold it stalled for five cycles.
    step(0, 1, 0, 6'b000010, 0, rdy);
    chk("sel_lane2", int'(sel), 4);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 3, 0, 0, rdy);
      chk("stall_ready", int'(rdy), 0);
    end
    step(0, 1, 3, 6'b000100, 0, rdy);
    chk("stall_release", int'(out_2), 3);
    chk("stall_sel", int'(sel), 8);

    // Reset mid-stream with three lanes valid.
    step(1, 0, 0, 0, 0, rdy);
    for (int w = 1; w <= 3; w++) step(0, 1, w, 0, 0, rdy);
    chk("three_valid", int'(out_valid), 7);
    step(1, 1, 6, 0, 0, rdy);
    chk("midreset_valid", int'(out_valid), 0);
    chk("midreset_sel", int'(sel), 1);
    step(0, 0, 0, 0, 0, rdy);
    chk("midreset_nodeliver", int'(out_valid), 0);

    // Wrap: twelve back-to-back words with every lane draining.
    nready = 0;
    for (int w = 0; w < 12; w++) begin
      step(0, 1, (w % 7) + 1, 6'b111111, 0, rdy);
      if (in_ready === 1'b1) nready++;
    end
    chk("wrap_ready_count", nready, 12);
    chk("wrap_sel", int'(sel), 1);
    chk("wrap_out5", int'(out_5), 5);
`else
    // Addressed delivery and illegal-destination drop.
    step(0, 1, 5, 0, 4, rdy);
    chk("addr_out4", int'(out_4), 5);
    chk("addr_valid4", int'(out_valid), 6'b010000);
    step(0, 1, 3, 0, 7, rdy);
    chk("illegal_ready", int'(rdy), 1);
    chk("illegal_err", int'(err), 1);
    chk("illegal_valid", int'(out_valid), 6'b010000);
    step(0, 0, 0, 0, 0, rdy);
    chk("err_one_cycle", int'(err), 0);
    chk("addr_sel", int'(sel), 1);
`endif

    // Randomized traffic against the model.
    step(1, 0, 0, 0, 0, rdy);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 31) == 0), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 7)), rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
